// File: rtl/trading_pkg.sv
// Shared constants, order layout and engine state for the UDP order path.
package trading_pkg;

    localparam int unsigned HEADER_LEN  = 42;
    localparam int unsigned PAYLOAD_LEN = 4;
    localparam int unsigned FRAME_LEN   = HEADER_LEN + PAYLOAD_LEN;
    localparam int unsigned CNT_W       = 6;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned PRICE_W     = 16;
    localparam int unsigned QTY_W       = 14;

    localparam int unsigned PRICE_MSB = 31;
    localparam int unsigned PRICE_LSB = 16;
    localparam int unsigned BUY_BIT   = 15;
    localparam int unsigned BOT_BIT   = 14;
    localparam int unsigned QTY_MSB   = 13;

    localparam int unsigned QTY_MAX = 16383;

    typedef struct packed {
        logic [PRICE_W-1:0] price;
        logic               is_buy;
        logic               is_bot;
        logic [QTY_W-1:0]   qty;
    } order_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MATCH = 1'b1
    } state_t;

    function automatic logic [QTY_W-1:0] qty_min(input logic [QTY_W-1:0] a,
                                                 input logic [QTY_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Equal-price joins saturate instead of wrapping the resting quantity.
    function automatic logic [QTY_W-1:0] qty_sat_add(input logic [QTY_W-1:0] a,
                                                     input logic [QTY_W-1:0] b);
        logic [QTY_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[QTY_W] ? QTY_W'(QTY_MAX) : sum[QTY_W-1:0];
    endfunction

endpackage

// File: rtl/udp_order_sniffer.sv
// Skips the Ethernet/IP/UDP header and assembles the big-endian order word.
// STRICT_LENGTH_EN: when defined, only frames of exactly FRAME_LEN bytes are released.
module udp_order_sniffer
    import trading_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tdata,
    input  logic              tvalid,
    input  logic              tlast,
    output logic              order_valid,
    output order_t            order_data
);

    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_next;
    logic              in_payload;
    logic              len_ok;

    assign in_payload = (cnt >= CNT_W'(HEADER_LEN)) && (cnt < CNT_W'(FRAME_LEN));
    assign word_next  = in_payload ? {word[WORD_W-BYTE_W-1:0], tdata} : word;

`ifdef STRICT_LENGTH_EN
    assign len_ok = (cnt == CNT_W'(FRAME_LEN - 1));
`else
    assign len_ok = (cnt >= CNT_W'(FRAME_LEN - 1));
`endif

    // Same-cycle release so the engine registers the order on the edge after tlast.
    assign order_valid       = tvalid && tlast && len_ok;
    assign order_data.price  = word_next[PRICE_MSB:PRICE_LSB];
    assign order_data.is_buy = word_next[BUY_BIT];
    assign order_data.is_bot = word_next[BOT_BIT];
    assign order_data.qty    = word_next[QTY_MSB:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (tvalid) begin
            word <= word_next;
            if (tlast) begin
                cnt <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/trading_system.sv
// UDP order front end plus one-level bid/ask matching engine.
// STRICT_LENGTH_EN (in udp_order_sniffer) restricts accepted frames to exactly 46 bytes.
module trading_system
    import trading_pkg::*;
(
    input  logic              clk_udp,
    input  logic              rst_udp,
    input  logic [BYTE_W-1:0] rx_axis_tdata,
    input  logic              rx_axis_tvalid,
    input  logic              rx_axis_tlast,
    output logic [WORD_W-1:0] trade_info,
    output logic              trade_valid,
    output logic              engine_busy,
    output logic [3:0]        leds
);

    state_t             state;
    order_t             ord;
    logic               order_valid;
    order_t             order_data;

    logic               bid_valid, ask_valid;
    logic [PRICE_W-1:0] bid_price, ask_price;
    logic [QTY_W-1:0]   bid_qty,   ask_qty;
    logic               led_order, led_trade;

    logic               nb_valid,  na_valid;
    logic [PRICE_W-1:0] nb_price,  na_price;
    logic [QTY_W-1:0]   nb_qty,    na_qty;
    logic               hit;
    logic [QTY_W-1:0]   fill;
    logic [QTY_W-1:0]   remain;
    logic [WORD_W-1:0]  fill_info;

    udp_order_sniffer u_sniffer (
        .clk         (clk_udp),
        .rst         (rst_udp),
        .tdata       (rx_axis_tdata),
        .tvalid      (rx_axis_tvalid),
        .tlast       (rx_axis_tlast),
        .order_valid (order_valid),
        .order_data  (order_data)
    );

    // Next book and fill for the order held in ord (used in MATCH only).
    always_comb begin
        nb_valid  = bid_valid;
        nb_price  = bid_price;
        nb_qty    = bid_qty;
        na_valid  = ask_valid;
        na_price  = ask_price;
        na_qty    = ask_qty;
        hit       = 1'b0;
        fill      = '0;
        remain    = '0;
        fill_info = '0;
        if (ord.qty != '0) begin
            if (ord.is_buy) begin
                hit = ask_valid && (ord.price >= ask_price);
                if (hit) begin
                    fill     = qty_min(ord.qty, ask_qty);
                    na_qty   = ask_qty - fill;
                    na_valid = (ask_qty != fill);
                end
                fill_info = {ask_price, 1'b1, ord.is_bot, fill};
                remain    = ord.qty - fill;
                if (remain != '0) begin
                    if (!bid_valid || ord.price > bid_price) begin
                        nb_valid = 1'b1;
                        nb_price = ord.price;
                        nb_qty   = remain;
                    end else if (ord.price == bid_price) begin
                        nb_qty = qty_sat_add(bid_qty, remain);
                    end
                end
            end else begin
                hit = bid_valid && (ord.price <= bid_price);
                if (hit) begin
                    fill     = qty_min(ord.qty, bid_qty);
                    nb_qty   = bid_qty - fill;
                    nb_valid = (bid_qty != fill);
                end
                fill_info = {bid_price, 1'b0, ord.is_bot, fill};
                remain    = ord.qty - fill;
                if (remain != '0) begin
                    if (!ask_valid || ord.price < ask_price) begin
                        na_valid = 1'b1;
                        na_price = ord.price;
                        na_qty   = remain;
                    end else if (ord.price == ask_price) begin
                        na_qty = qty_sat_add(ask_qty, remain);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_udp or posedge rst_udp) begin
        if (rst_udp) begin
            state       <= ST_IDLE;
            ord         <= '0;
            bid_valid   <= 1'b0;
            bid_price   <= '0;
            bid_qty     <= '0;
            ask_valid   <= 1'b0;
            ask_price   <= '0;
            ask_qty     <= '0;
            trade_info  <= '0;
            trade_valid <= 1'b0;
            engine_busy <= 1'b0;
            led_order   <= 1'b0;
            led_trade   <= 1'b0;
        end else begin
            trade_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (order_valid) begin
                        ord         <= order_data;
                        state       <= ST_MATCH;
                        engine_busy <= 1'b1;
                        led_order   <= ~led_order;
                    end
                end
                ST_MATCH: begin
                    state       <= ST_IDLE;
                    engine_busy <= 1'b0;
                    bid_valid   <= nb_valid;
                    bid_price   <= nb_price;
                    bid_qty     <= nb_qty;
                    ask_valid   <= na_valid;
                    ask_price   <= na_price;
                    ask_qty     <= na_qty;
                    if (hit) begin
                        trade_valid <= 1'b1;
                        trade_info  <= fill_info;
                        led_trade   <= ~led_trade;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign leds = {ask_valid, bid_valid, led_trade, led_order};

endmodule

// File: tb/tb_trading_system.sv
// Directed, table-driven bench for trading_system; expectations adapt to STRICT_LENGTH_EN.
module tb_trading_system;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;
    logic [31:0] trade_info;
    logic        trade_valid;
    logic        engine_busy;
    logic [3:0]  leds;

    int checks = 0;
    int passes = 0;
    logic [31:0] last_info;

    typedef struct {
        logic [31:0] payload;
        int          nbytes;
        bit          gapped;
        bit          accept;
        bit          trade;
        logic [31:0] info;
        logic [3:0]  leds;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs[14];

    always #4 clk = ~clk;

    trading_system dut (
        .clk_udp        (clk),
        .rst_udp        (rst),
        .rx_axis_tdata  (tdata),
        .rx_axis_tvalid (tvalid),
        .rx_axis_tlast  (tlast),
        .trade_info     (trade_info),
        .trade_valid    (trade_valid),
        .engine_busy    (engine_busy),
        .leds           (leds)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] p, input int idx);
        if (idx < 42)      return 8'(idx);
        else if (idx < 46) return p[8*(45-idx) +: 8];
        else               return 8'hEE;
    endfunction

    // Drives bytes first..last_idx; returns at the falling edge after the last byte is sampled.
    task automatic send_bytes(input logic [31:0] payload, input int first, input int last_idx,
                              input bit with_tlast, input bit gapped);
        for (int i = first; i <= last_idx; i++) begin
            if (gapped) begin
                int gaps;
                gaps = int'($urandom_range(0, 2));
                for (int g = 0; g < gaps; g++) begin
                    @(negedge clk);
                    tvalid = 1'b0;
                    tdata  = 8'($urandom);
                    tlast  = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            tdata  = byte_at(payload, i);
            tvalid = 1'b1;
            tlast  = with_tlast && (i == last_idx);
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        send_bytes(v.payload, 0, v.nbytes - 1, 1'b1, v.gapped);
        chk($sformatf("v%0d busy_n1", i), 32'(engine_busy), 32'(v.accept));
        chk($sformatf("v%0d tv_n1", i), 32'(trade_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d busy_n2", i), 32'(engine_busy), 32'd0);
        chk($sformatf("v%0d tv_n2", i), 32'(trade_valid), 32'(v.trade));
        if (v.trade) last_info = v.info;
        chk($sformatf("v%0d info", i), trade_info, last_info);
        chk($sformatf("v%0d leds", i), 32'(leds & v.mask), 32'(v.leds & v.mask));
        @(negedge clk);
        chk($sformatf("v%0d tv_n3", i), 32'(trade_valid), 32'd0);
    endtask

    initial begin
        //          payload       len gap acc trd info          leds     mask
        vecs[0]  = '{32'h00018001, 46, 0, 1, 0, 32'h0,        4'b0101, 4'hF};
        vecs[1]  = '{32'h00FF000A, 46, 0, 1, 0, 32'h0,        4'b1100, 4'hF};
        vecs[2]  = '{32'h012C8004, 46, 0, 1, 1, 32'h00FF8004, 4'b1111, 4'hF};
        vecs[3]  = '{32'h00010003, 46, 0, 1, 1, 32'h00010001, 4'b1000, 4'hF};
        vecs[4]  = '{32'h00018002, 40, 0, 0, 0, 32'h0,        4'b1000, 4'hF};
`ifdef STRICT_LENGTH_EN
        vecs[5]  = '{32'h00018002, 50, 0, 0, 0, 32'h0,        4'b1000, 4'hF};
`else
        vecs[5]  = '{32'h00018002, 50, 0, 1, 1, 32'h00018002, 4'b0011, 4'hF};
`endif
        vecs[6]  = '{32'h00648005, 46, 1, 1, 0, 32'h0,        4'b0101, 4'hF};
        vecs[7]  = '{32'h005A0008, 46, 1, 1, 1, 32'h00640005, 4'b1010, 4'hF};
        vecs[8]  = '{32'h005A3FFF, 46, 0, 1, 0, 32'h0,        4'b1011, 4'hF};
        vecs[9]  = '{32'h005ABFFF, 46, 1, 1, 1, 32'h005ABFFF, 4'b0000, 4'hF};
        vecs[10] = '{32'h00328001, 46, 0, 1, 0, 32'h0,        4'b0101, 4'hF};
        vecs[11] = '{32'h00288009, 46, 0, 1, 0, 32'h0,        4'b0100, 4'hF};
        vecs[12] = '{32'h000A0009, 46, 0, 1, 1, 32'h00320001, 4'b1011, 4'hF};
        vecs[13] = '{32'h00FF8000, 46, 0, 1, 0, 32'h0,        4'b1010, 4'b1110};

        rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        last_info = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst trade_info", trade_info, 32'd0);
        chk("rst trade_valid", 32'(trade_valid), 32'd0);
        chk("rst busy", 32'(engine_busy), 32'd0);
        chk("rst leds", 32'(leds), 32'd0);

        for (int i = 0; i <= 5; i++) apply_vec(i);

        // Reset in the middle of a frame: partial frame and book are discarded.
        send_bytes(32'h00018001, 0, 19, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_info = '0;
        @(negedge clk);
        chk("midrst leds", 32'(leds), 32'd0);
        chk("midrst info", trade_info, 32'd0);
        send_bytes(32'h00018001, 20, 45, 1'b1, 1'b0);
        chk("tail busy", 32'(engine_busy), 32'd0);
        @(negedge clk);
        chk("tail tv", 32'(trade_valid), 32'd0);
        chk("tail leds", 32'(leds), 32'd0);

        for (int i = 6; i <= 13; i++) apply_vec(i);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
